// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single reg_file write port between two writeback slots
//   (A = older, B = younger). Accepted results go into an in-order FIFO that
//   drains one write per cycle. Writes to r0 are dropped. When A and B target
//   the same register in the same cycle, only B's result is kept. Two hazard
//   query ports report whether a write to a given register is still pending.
// Ports
//   i_clk, i_rst_n            clock; asynchronous active-low reset
//   i_a_* / o_a_ready         slot A valid/dest/data and its ready
//   i_b_* / o_b_ready         slot B valid/dest/data and its ready
//   i_hold                    suspend draining
//   o_rf_write/_wr/_wd        reg_file write port (FIFO head)
//   i_q_addrK / o_q_hitK      pending-write hazard queries (K = 1, 2)
//   o_count                   occupied FIFO entries
module rf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_a_valid,
  output logic          o_a_ready,
  input  logic [AW-1:0] i_a_wr,
  input  logic [DW-1:0] i_a_wd,
  input  logic          i_b_valid,
  output logic          o_b_ready,
  input  logic [AW-1:0] i_b_wr,
  input  logic [DW-1:0] i_b_wd,
  input  logic          i_hold,
  output logic          o_rf_write,
  output logic [AW-1:0] o_rf_wr,
  output logic [DW-1:0] o_rf_wd,
  input  logic [AW-1:0] i_q_addr1,
  output logic          o_q_hit1,
  input  logic [AW-1:0] i_q_addr2,
  output logic          o_q_hit2,
  output logic [CW-1:0] o_count
);

  logic [DEPTH-1:0][AW-1:0] r_addr;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [DEPTH-1:0]         r_vld;
  logic [PW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]            r_count;

  logic          w_a_acc, w_b_acc, w_st_a, w_st_b, w_deq, w_nonempty;
  logic [PW-1:0] w_b_slot;
  logic [DEPTH-1:0] w_hit1, w_hit2;

  // Ready depends only on registered occupancy, never on this cycle's drain.
  assign o_a_ready = (r_count <= CW'(DEPTH - 1));
  assign o_b_ready = (r_count <= CW'(DEPTH - 2));

  assign w_a_acc = i_a_valid & o_a_ready;
  assign w_b_acc = i_b_valid & o_b_ready;

  // r0 writes complete the handshake but store nothing; on a same-register
  // pair the younger slot B wins and A is discarded.
  assign w_st_b   = w_b_acc & (i_b_wr != '0);
  assign w_st_a   = w_a_acc & (i_a_wr != '0) & ~(w_st_b & (i_b_wr == i_a_wr));
  assign w_b_slot = r_wr_ptr + PW'(w_st_a);

  assign w_nonempty = (r_count != '0);
  assign w_deq      = w_nonempty & ~i_hold;

  assign o_rf_write = w_deq;
  assign o_rf_wr    = w_nonempty ? r_addr[r_rd_ptr] : '0;
  assign o_rf_wd    = w_nonempty ? r_data[r_rd_ptr] : '0;
  assign o_count    = r_count;

  always_comb begin
    w_hit1 = '0;
    w_hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hit1[i] = r_vld[i] & (r_addr[i] == i_q_addr1);
      w_hit2[i] = r_vld[i] & (r_addr[i] == i_q_addr2);
    end
  end

  assign o_q_hit1 = (i_q_addr1 != '0) & (|w_hit1);
  assign o_q_hit2 = (i_q_addr2 != '0) & (|w_hit2);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_data   <= '0;
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // A slot being enqueued is never the head being popped (no enqueue
      // when full), so clear-then-set ordering is safe.
      if (w_deq) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_st_a) begin
        r_addr[r_wr_ptr] <= i_a_wr;
        r_data[r_wr_ptr] <= i_a_wd;
        r_vld[r_wr_ptr]  <= 1'b1;
      end
      if (w_st_b) begin
        r_addr[w_b_slot] <= i_b_wr;
        r_data[w_b_slot] <= i_b_wd;
        r_vld[w_b_slot]  <= 1'b1;
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_st_a) + PW'(w_st_b);
      r_count  <= r_count + CW'(w_st_a) + CW'(w_st_b) - CW'(w_deq);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk, rst_n;
  logic          a_valid, a_ready, b_valid, b_ready, hold;
  logic [AW-1:0] a_wr, b_wr, q_addr1, q_addr2, rf_wr;
  logic [DW-1:0] a_wd, b_wd, rf_wd;
  logic          rf_write, q_hit1, q_hit2;
  logic [CW-1:0] count;

  rf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_a_valid(a_valid), .o_a_ready(a_ready), .i_a_wr(a_wr), .i_a_wd(a_wd),
    .i_b_valid(b_valid), .o_b_ready(b_ready), .i_b_wr(b_wr), .i_b_wd(b_wd),
    .i_hold(hold), .o_rf_write(rf_write), .o_rf_wr(rf_wr), .o_rf_wd(rf_wd),
    .i_q_addr1(q_addr1), .o_q_hit1(q_hit1), .i_q_addr2(q_addr2), .o_q_hit2(q_hit2),
    .o_count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Behavioural model: the pending writes as a plain queue in write order.
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t mq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mq.delete();
    else begin
      int  cnt;
      bit  acc_a, acc_b, keep_a, keep_b;
      cnt    = mq.size();
      acc_a  = a_valid && (DEPTH - cnt >= 1);
      acc_b  = b_valid && (DEPTH - cnt >= 2);
      keep_b = acc_b && (b_wr != 0);
      keep_a = acc_a && (a_wr != 0) && !(keep_b && a_wr == b_wr);
      if (cnt != 0 && !hold) void'(mq.pop_front());
      if (keep_a) mq.push_back('{a: a_wr, d: a_wd});
      if (keep_b) mq.push_back('{a: b_wr, d: b_wd});
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      int cnt;
      bit h1, h2;
      cnt = mq.size();
      h1 = 0; h2 = 0;
      foreach (mq[i]) begin
        if (mq[i].a == q_addr1 && q_addr1 != 0) h1 = 1;
        if (mq[i].a == q_addr2 && q_addr2 != 0) h2 = 1;
      end
      chk("count",    32'(count),    32'(cnt));
      chk("a_ready",  32'(a_ready),  32'(DEPTH - cnt >= 1));
      chk("b_ready",  32'(b_ready),  32'(DEPTH - cnt >= 2));
      chk("rf_write", 32'(rf_write), 32'(cnt != 0 && !hold));
      chk("rf_wr",    32'(rf_wr),    cnt != 0 ? 32'(mq[0].a) : 32'd0);
      chk("rf_wd",    rf_wd,         cnt != 0 ? mq[0].d : 32'd0);
      chk("q_hit1",   32'(q_hit1),   32'(h1));
      chk("q_hit2",   32'(q_hit2),   32'(h2));
    end
  end

  // Register file stand-in plus a log of the writes it actually received.
  logic [DW-1:0] rf [32];
  ent_t wlog[$];
  bit   pend;
  ent_t pend_e;
  always @(negedge clk) begin
    pend   = rst_n && rf_write;
    pend_e = '{a: rf_wr, d: rf_wd};
  end
  always @(posedge clk) begin
    if (rst_n && pend) begin
      rf[pend_e.a] = pend_e.d;
      wlog.push_back(pend_e);
    end
    pend = 0;
  end

  task automatic step(input logic av, input logic [AW-1:0] aw, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] bw, input logic [DW-1:0] bd,
                      input logic h);
    a_valid = av; a_wr = aw; a_wd = ad;
    b_valid = bv; b_wr = bw; b_wd = bd;
    hold = h;
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
  endtask

  task automatic idle(input logic h);
    step(0, 0, 0, 0, 0, 0, h);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end before 100000");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [31:0] seq;
    rst_n = 0; a_valid = 0; b_valid = 0; hold = 0;
    a_wr = 0; b_wr = 0; a_wd = 0; b_wd = 0; q_addr1 = 0; q_addr2 = 0;
    foreach (rf[i]) rf[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    // 1: reset state
    chk("rst_rf_write", 32'(rf_write), 0);
    chk("rst_count",    32'(count),    0);
    chk("rst_readies",  32'({a_ready, b_ready}), 32'b11);
    chk("rst_hit1",     32'(q_hit1),   0);
    rst_n = 1;
    idle(0);

    // 2: single A write, one-cycle latency
    step(1, 5'd1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("t2_rf_write", 32'(rf_write), 1);
    chk("t2_rf_wr",    32'(rf_wr),    1);
    chk("t2_rf_wd",    rf_wd,         32'hFFFF_FFFF);
    idle(0);
    chk("t2_r1",       rf[1],         32'hFFFF_FFFF);
    chk("t2_count",    32'(count),    0);

    // 3: A+B pair, in-order drain, hazard on r3 for two cycles
    q_addr1 = 5'd3; q_addr2 = 5'd2;
    step(1, 5'd2, 32'h0FFF_FFFF, 1, 5'd3, 32'h00FF_FFFF, 0);
    chk("t3_hit_c1", 32'(q_hit1), 1);
    idle(0);
    chk("t3_hit_c2", 32'(q_hit1), 1);
    idle(0);
    chk("t3_hit_c3", 32'(q_hit1), 0);
    n0 = wlog.size();
    seq = {22'd0, wlog[n0-2].a, wlog[n0-1].a};
    chk("t3_order", seq, {22'd0, 5'd2, 5'd3});
    chk("t3_r3", rf[3], 32'h00FF_FFFF);

    // 4: same-cycle WAW collapses to B
    q_addr1 = 5'd4; q_addr2 = 5'd0;
    n0 = wlog.size();
    step(1, 5'd4, 32'h000F_FFFF, 1, 5'd4, 32'h0000_FFFF, 0);
    chk("t4_count", 32'(count), 1);
    idle(0); idle(0);
    chk("t4_nwrites", 32'(wlog.size() - n0), 1);
    chk("t4_r4", rf[4], 32'h0000_FFFF);

    // 5: hold fills the FIFO, then drain with an enqueue at full-1
    q_addr1 = 5'd8; q_addr2 = 5'd11;
    n0 = wlog.size();
    step(1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 1);
    step(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 1);
    chk("t5_count_full", 32'(count), 4);
    chk("t5_readies",    32'({a_ready, b_ready}), 0);
    chk("t5_rf_write",   32'(rf_write), 0);
    idle(0);
    chk("t5_count3",     32'(count), 3);
    chk("t5_ready3",     32'({a_ready, b_ready}), 32'b10);
    step(1, 5'd11, 32'hBB, 0, 0, 0, 0);
    chk("t5_count_eqdq", 32'(count), 3);
    idle(0);
    chk("t5_ready2",     32'({a_ready, b_ready}), 32'b11);
    repeat (3) idle(0);
    chk("t5_drained",    32'(count), 0);
    seq = {7'd0, wlog[n0].a, wlog[n0+1].a, wlog[n0+2].a, wlog[n0+3].a, wlog[n0+4].a};
    chk("t5_order", seq, {7'd0, 5'd5, 5'd6, 5'd7, 5'd8, 5'd11});
    chk("t5_nwrites", 32'(wlog.size() - n0), 5);

    // 6: r0 dropped; reset mid-drain discards pending writes
    step(1, 5'd0, 32'hDEAD, 0, 0, 0, 0);
    chk("t6_r0_count", 32'(count), 0);
    chk("t6_r0_write", 32'(rf_write), 0);
    q_addr1 = 5'd10;
    step(1, 5'd9, 32'h99, 1, 5'd10, 32'hAA, 1);
    hold = 0;
    @(posedge clk); #1;
    chk("t6_mid_write", 32'(rf_write), 1);
    n0 = wlog.size();
    rst_n = 0;
    #1;
    chk("t6_rst_write", 32'(rf_write), 0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_hit",   32'(q_hit1), 0);
    @(posedge clk); #1;
    rst_n = 1;
    idle(0); idle(0);
    chk("t6_no_write", 32'(wlog.size() - n0), 0);
    chk("t6_count", 32'(count), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
